// File: rtl/manchester_rx_decoder.sv
// Manchester receive decoder: oversamples line_in, locks on the start bit,
// recovers 8 data bits MSB-first from mid-bit edges, strobes each byte.
// Optional feature macro: MANCH_PARITY_EN (adds an even-parity ninth bit).
module manchester_rx_decoder #(
    parameter int HALF = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       line_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(3*HALF);
    localparam int IW = $clog2(2*HALF+1);
`ifdef MANCH_PARITY_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int BW = $clog2(NBITS);
    localparam int SW = NBITS - 1;

    localparam logic [CW-1:0] BLANK_END = CW'((3*HALF)/2);
    localparam logic [CW-1:0] TMO       = CW'((5*HALF)/2);
    localparam logic [IW-1:0] IDLE_LAST = IW'(2*HALF - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, HUNT, BLANK, WINDOW} state_t;

    state_t        state, state_nxt;
    logic          s1, s2, s3;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic [BW-1:0] bidx, bidx_nxt;
    logic [SW-1:0] shreg, shreg_nxt;
    logic [NBITS-1:0] full;
    logic [7:0]    dout_nxt;
    logic          dv_nxt, fe_nxt;
    logic          line_edge, line_rise;

    // Three-flop front end; only the last two stages feed the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= line_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign line_edge = s2 ^ s3;
    assign line_rise = s2 & ~s3;
    assign cnt_inc   = cnt + 1'b1;
    // Shift register contents as they will be once the current bit lands
    assign full      = {shreg, s2};
    assign busy      = (state == BLANK) || (state == WINDOW);

    // State, counters and registered output strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idle_cnt   <= '0;
            bidx       <= '0;
            shreg      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idle_cnt   <= idle_nxt;
            bidx       <= bidx_nxt;
            shreg      <= shreg_nxt;
            data_out   <= dout_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
        end
    end

    // Next-state: idle qualification, start hunt, blanking, mid-bit window
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idle_nxt  = idle_cnt;
        bidx_nxt  = bidx;
        shreg_nxt = shreg;
        dout_nxt  = data_out;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            idle_nxt  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Require a long low stretch so a trailing fall after a
                    // final 1 is never mistaken for the next start bit
                    if (s2) begin
                        idle_nxt = '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        idle_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        idle_nxt = idle_cnt + 1'b1;
                    end
                end
                HUNT: begin
                    if (line_rise) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        bidx_nxt  = '0;
                    end
                end
                BLANK: begin
                    // Edges here are bit-boundary edges and carry no data
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == BLANK_END) state_nxt = WINDOW;
                end
                WINDOW: begin
                    if (line_edge) begin
                        shreg_nxt = full[SW-1:0];
                        cnt_nxt   = '0;
                        if (bidx == LAST_BIT) begin
                            state_nxt = IDLE;
`ifdef MANCH_PARITY_EN
                            if (^full == 1'b0) begin
                                dout_nxt = full[8:1];
                                dv_nxt   = 1'b1;
                            end else begin
                                fe_nxt = 1'b1;
                            end
`else
                            dout_nxt = full[7:0];
                            dv_nxt   = 1'b1;
`endif
                        end else begin
                            bidx_nxt  = bidx + 1'b1;
                            state_nxt = BLANK;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == TMO) begin
                            fe_nxt    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
